// File: rtl/dp_ram.sv
// Simple dual-port RAM: one write port, one read port, single clock, read-first on same-address collision.
// Latency: rddata/collision valid 1 cycle after rdaddr is sampled (2 cycles with OUTREG=1).
// Backpressure: none; one write and one read accepted every cycle.
module dp_ram #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 4,
    parameter bit OUTREG     = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wren,
    input  logic [ADDR_WIDTH-1:0] wraddr,
    input  logic [DATA_WIDTH-1:0] wrdata,
    input  logic [ADDR_WIDTH-1:0] rdaddr,
    output logic [DATA_WIDTH-1:0] rddata,
    output logic                  collision
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_q;
    logic                  coll_q;
    logic                  wr_go;
    logic                  coll_d;

    // Writes are blocked while reset is held; the array itself is never cleared.
    assign wr_go  = wren & rst_n;
    assign coll_d = wren & (wraddr == rdaddr);

    always_ff @(posedge clk) begin
        if (wr_go) begin
            mem[wraddr] <= wrdata;
        end
    end

    // Nonblocking read of the array gives read-first behaviour on a same-address write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q   <= '0;
            coll_q <= 1'b0;
        end else begin
            rd_q   <= mem[rdaddr];
            coll_q <= coll_d;
        end
    end

    generate
        if (OUTREG) begin : g_outreg
            logic [DATA_WIDTH-1:0] rd_q2;
            logic                  coll_q2;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rd_q2   <= '0;
                    coll_q2 <= 1'b0;
                end else begin
                    rd_q2   <= rd_q;
                    coll_q2 <= coll_q;
                end
            end

            assign rddata    = rd_q2;
            assign collision = coll_q2;
        end else begin : g_noreg
            assign rddata    = rd_q;
            assign collision = coll_q;
        end
    endgenerate

endmodule

// File: tb/tb_dp_ram.sv
// Bench for dp_ram: one instance with OUTREG=0 and one with OUTREG=1 share stimulus;
// an abstract memory model feeds per-instance expectation queues drained by monitors.
module tb_dp_ram;

    logic       clk;
    logic       rst_n;
    logic       wren;
    logic [3:0] wraddr;
    logic [3:0] wrdata;
    logic [3:0] rdaddr;
    logic [3:0] rd0;
    logic       col0;
    logic [3:0] rd1;
    logic       col1;

    int checks = 0;
    int errors = 0;

    dp_ram #(.ADDR_WIDTH(4), .DATA_WIDTH(4), .OUTREG(1'b0)) u_ram0 (
        .clk(clk), .rst_n(rst_n), .wren(wren), .wraddr(wraddr), .wrdata(wrdata),
        .rdaddr(rdaddr), .rddata(rd0), .collision(col0)
    );

    dp_ram #(.ADDR_WIDTH(4), .DATA_WIDTH(4), .OUTREG(1'b1)) u_ram1 (
        .clk(clk), .rst_n(rst_n), .wren(wren), .wraddr(wraddr), .wrdata(wrdata),
        .rdaddr(rdaddr), .rddata(rd1), .collision(col1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] data;
        logic       coll;
        bit         known;
    } exp_t;

    exp_t       q0[$];
    exp_t       q1[$];
    logic [3:0] ref_mem [16];
    bit         ref_vld [16];
    bit         needseed = 1'b1;

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: memory as an array with per-word "written" flags.
    always @(posedge clk) begin
        exp_t e;
        if (!rst_n) begin
            q0.delete();
            q1.delete();
            needseed = 1'b1;
        end else begin
            if (needseed) begin
                q1.push_back('{data: 4'h0, coll: 1'b0, known: 1'b1});
                needseed = 1'b0;
            end
            e.known = ref_vld[rdaddr];
            e.data  = ref_mem[rdaddr];
            e.coll  = (wren === 1'b1) ? (wraddr == rdaddr) : 1'b0;
            q0.push_back(e);
            q1.push_back(e);
            if (wren === 1'b1) begin
                ref_mem[wraddr] = wrdata;
                ref_vld[wraddr] = 1'b1;
            end
        end
    end

    always @(posedge clk) begin
        logic r0;
        exp_t e0;
        r0 = rst_n;
        #1;
        if (r0) begin
            if (q0.size() == 0) begin
                chk("q0_underflow", 4'h1, 4'h0);
            end else begin
                e0 = q0.pop_front();
                if (e0.known) chk("rddata_o0", rd0, e0.data);
                chk("collision_o0", {3'b0, col0}, {3'b0, e0.coll});
            end
        end
    end

    always @(posedge clk) begin
        logic r1;
        exp_t e1;
        r1 = rst_n;
        #1;
        if (r1) begin
            if (q1.size() == 0) begin
                chk("q1_underflow", 4'h1, 4'h0);
            end else begin
                e1 = q1.pop_front();
                if (e1.known) chk("rddata_o1", rd1, e1.data);
                chk("collision_o1", {3'b0, col1}, {3'b0, e1.coll});
            end
        end
    end

    task automatic step(input logic we, input logic [3:0] wa, input logic [3:0] wd,
                        input logic [3:0] ra);
        @(negedge clk);
        wren   = we;
        wraddr = wa;
        wrdata = wd;
        rdaddr = ra;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_rd0"}, rd0, 4'h0);
        chk({tag, "_col0"}, {3'b0, col0}, 4'h0);
        chk({tag, "_rd1"}, rd1, 4'h0);
        chk({tag, "_col1"}, {3'b0, col1}, 4'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] a;
        logic [3:0] d;
        for (int i = 0; i < 16; i++) ref_vld[i] = 1'b0;
        wren = 1'b0; wraddr = '0; wrdata = '0; rdaddr = '0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1 check_zero("rst_init");

        // Reset held with toggling read address; writes here must be ignored.
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 4'(i + 8), 4'(i), 4'(i[0] ? 4'hF : 4'h0));
            #1 check_zero("rst_hold");
        end
        @(negedge clk) rst_n = 1'b1;

        for (int i = 0; i < 8; i++) step(1'b1, 4'(i), 4'(i), 4'(15 - i));
        for (int i = 7; i >= 0; i--) step(1'b0, 4'bx, 4'bx, 4'(i));

        step(1'b0, 4'h3, 4'hF, 4'h3);
        step(1'b0, 4'h3, 4'hF, 4'h3);

        // Read-first collision on address 5, then the new value next cycle.
        step(1'b1, 4'h5, 4'hA, 4'h5);
        step(1'b0, 4'bx, 4'bx, 4'h5);

        for (int i = 0; i < 16; i++) step(1'b1, 4'(i), ~4'(i), 4'(i));
        for (int i = 0; i < 16; i++) step(1'b0, 4'bx, 4'bx, 4'(i));

        for (int i = 0; i < 300; i++) begin
            a = 4'($urandom_range(0, 15));
            d = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) step(1'b1, a, d, a);
            else step(1'($urandom_range(0, 1)), a, d, 4'($urandom_range(0, 15)));
        end

        // Mid-operation reset: outputs clear at once, memory survives, writes blocked.
        @(negedge clk);
        rst_n = 1'b0;
        #1 check_zero("rst_mid");
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 4'(i), 4'($urandom_range(0, 15)), 4'(i));
            #1 check_zero("rst_mid_hold");
        end
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 16; i++) step(1'b0, 4'bx, 4'bx, 4'(i));

        for (int i = 0; i < 100; i++) begin
            step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end

        for (int i = 0; i < 4; i++) step(1'b0, 4'bx, 4'bx, 4'(i));
        @(negedge clk);
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
